// File: rtl/dct_transpose_if.sv
// Handshake and RAM bus between the row-DCT stage, the transpose RAM and the column-DCT stage.
// The master side is the transpose controller; the slave side is its environment.
interface dct_transpose_if #(
   parameter int DATA_W = 24,
   parameter int ADDR_W = 6
) ();
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_we;
   logic [DATA_W-1:0] ram_din;
   logic [DATA_W-1:0] ram_dout;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              out_ready;
   logic              block_done;

   modport master (
      input  in_valid, in_data, ram_dout, out_ready,
      output in_ready, ram_addr, ram_we, ram_din, out_valid, out_data, block_done
   );

   modport slave (
      output in_valid, in_data, ram_dout, out_ready,
      input  in_ready, ram_addr, ram_we, ram_din, out_valid, out_data, block_done
   );
endinterface

// File: rtl/dct_transpose_ctrl.sv
// Transpose-RAM sequencer: writes an 8x8 block row-major, reads it back column-major.
// Optional status outputs (frame_cnt, drop_err) are enabled by defining DCT_TC_STATUS_EN.
module dct_transpose_ctrl #(
   parameter int DATA_W = 24,
   parameter int LOG2N  = 3
) (
   input  logic                  clk,
   input  logic                  rst,
`ifdef DCT_TC_STATUS_EN
   output logic [15:0]           frame_cnt,
   output logic                  drop_err,
`endif
   dct_transpose_if.master       bus
);
   localparam int ADDR_W = 2 * LOG2N;
   localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};
   localparam logic [ADDR_W-1:0] ONE_IDX  = {{(ADDR_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      PRIME = 2'd2,
      DRAIN = 2'd3
   } state_t;

   state_t            state_r, state_nx_s;
   logic [ADDR_W-1:0] wr_cnt_r;
   logic [ADDR_W-1:0] rd_cnt_r;
   logic              out_valid_r;
   logic              block_done_r;
   logic              in_ready_s;
   logic              ram_we_s;
   logic [ADDR_W-1:0] ram_addr_s;
   logic              accept_s;
   logic              hs_s;
   logic              last_hs_s;
   logic [ADDR_W-1:0] rd_sel_s;

   // Column-major index k maps to row k%N, col k/N: swap the two halves of k.
   function automatic logic [ADDR_W-1:0] transpose_addr(input logic [ADDR_W-1:0] k);
      return {k[LOG2N-1:0], k[ADDR_W-1:LOG2N]};
   endfunction

   // Next-state decode and combinational RAM/handshake controls.
   always_comb begin
      state_nx_s = state_r;
      in_ready_s = 1'b0;
      ram_we_s   = 1'b0;
      ram_addr_s = {ADDR_W{1'b0}};
      accept_s   = 1'b0;
      hs_s       = 1'b0;
      last_hs_s  = 1'b0;
      rd_sel_s   = rd_cnt_r;
      case (state_r)
         IDLE, FILL: begin
            in_ready_s = 1'b1;
            ram_we_s   = bus.in_valid;
            ram_addr_s = wr_cnt_r;
            accept_s   = bus.in_valid;
            if (bus.in_valid) begin
               if (wr_cnt_r == LAST_IDX) begin
                  state_nx_s = PRIME;
               end else begin
                  state_nx_s = FILL;
               end
            end else begin
               state_nx_s = state_r;
            end
         end
         PRIME: begin
            ram_addr_s = transpose_addr({ADDR_W{1'b0}});
            state_nx_s = DRAIN;
         end
         DRAIN: begin
            hs_s      = out_valid_r & bus.out_ready;
            last_hs_s = hs_s & (rd_cnt_r == LAST_IDX);
            // Fetch the next word in the handshake cycle so the stream has no bubbles.
            if (hs_s) begin
               rd_sel_s = rd_cnt_r + ONE_IDX;
            end else begin
               rd_sel_s = rd_cnt_r;
            end
            ram_addr_s = transpose_addr(rd_sel_s);
            if (last_hs_s) begin
               state_nx_s = IDLE;
            end else begin
               state_nx_s = DRAIN;
            end
         end
         default: begin
            state_nx_s = IDLE;
         end
      endcase
   end

   // State, counters and registered handshake outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= IDLE;
         wr_cnt_r     <= {ADDR_W{1'b0}};
         rd_cnt_r     <= {ADDR_W{1'b0}};
         out_valid_r  <= 1'b0;
         block_done_r <= 1'b0;
      end else begin
         state_r      <= state_nx_s;
         block_done_r <= last_hs_s;
         if (accept_s) begin
            wr_cnt_r <= wr_cnt_r + ONE_IDX;
         end
         if (hs_s) begin
            rd_cnt_r <= rd_cnt_r + ONE_IDX;
         end
         if (state_r == PRIME) begin
            out_valid_r <= 1'b1;
         end else if (last_hs_s) begin
            out_valid_r <= 1'b0;
         end
      end
   end

`ifdef DCT_TC_STATUS_EN
   logic [15:0] frame_cnt_r;
   logic        drop_err_r;

   // Block counter and sticky flag for upstream data offered while the block drains.
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_cnt_r <= 16'd0;
         drop_err_r  <= 1'b0;
      end else begin
         if (block_done_r) begin
            frame_cnt_r <= frame_cnt_r + 16'd1;
         end
         if (bus.in_valid && ((state_r == PRIME) || (state_r == DRAIN))) begin
            drop_err_r <= 1'b1;
         end
      end
   end

   assign frame_cnt = frame_cnt_r;
   assign drop_err  = drop_err_r;
`endif

   assign bus.in_ready   = in_ready_s;
   assign bus.ram_we     = ram_we_s;
   assign bus.ram_addr   = ram_addr_s;
   assign bus.ram_din    = bus.in_data;
   assign bus.out_valid  = out_valid_r;
   assign bus.out_data   = bus.ram_dout;
   assign bus.block_done = block_done_r;
endmodule

// File: tb/tb_dct_transpose_ctrl.sv
// Scoreboard bench for dct_transpose_ctrl with a behavioural 64x24 registered-read RAM.
// Build with DCT_TC_STATUS_EN defined to also check frame_cnt and drop_err.
module tb_dct_transpose_ctrl;
   localparam int DATA_W = 24;
   localparam int ADDR_W = 6;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;
   bit   tog_mode = 1'b0;
   int   n_words = 0;
   logic [DATA_W-1:0] exp_q[$];
   logic [DATA_W-1:0] mem [0:63];
`ifdef DCT_TC_STATUS_EN
   logic [15:0] frame_cnt;
   logic        drop_err;
`endif

   dct_transpose_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   dct_transpose_ctrl #(.DATA_W(DATA_W), .LOG2N(3)) dut (
      .clk       (clk),
      .rst       (rst),
`ifdef DCT_TC_STATUS_EN
      .frame_cnt (frame_cnt),
      .drop_err  (drop_err),
`endif
      .bus       (bus.master)
   );

   always #5 clk = ~clk;

   // Single-port RAM, read data registered with one cycle of latency.
   always_ff @(posedge clk) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
      bus.ram_dout <= mem[bus.ram_addr];
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Downstream ready: constant 1, or alternating 1,0 when tog_mode is set.
   initial begin
      bus.out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         bus.out_ready = tog_mode ? ~bus.out_ready : 1'b1;
      end
   end

   // Monitor: pops expected words on handshakes, checks stalls, block_done and write gating.
   initial begin
      bit done_due;
      bit prev_stall;
      logic [DATA_W-1:0] prev_data;
      logic [DATA_W-1:0] e;
      done_due = 1'b0;
      prev_stall = 1'b0;
      prev_data = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            done_due = 1'b0;
            prev_stall = 1'b0;
         end else begin
            chk("block_done", {31'd0, bus.block_done}, {31'd0, done_due});
            done_due = 1'b0;
            if (prev_stall) chk("stall_hold", {8'd0, bus.out_data}, {8'd0, prev_data});
            if (bus.out_valid && bus.out_ready) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_out", 32'd1, 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  chk("out_data", {8'd0, bus.out_data}, {8'd0, e});
                  n_words++;
                  if (n_words % 64 == 0) done_due = 1'b1;
               end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data = bus.out_data;
            if (!bus.in_valid) chk("we_without_valid", {31'd0, bus.ram_we}, 32'd0);
         end
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      bus.in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
      chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_ram_we", {31'd0, bus.ram_we}, 32'd0);
      chk("rst_ram_addr", {26'd0, bus.ram_addr}, 32'd0);
      chk("rst_block_done", {31'd0, bus.block_done}, 32'd0);
`ifdef DCT_TC_STATUS_EN
      chk("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
      chk("rst_drop_err", {31'd0, drop_err}, 32'd0);
`endif
      @(posedge clk);
      #1;
   endtask

   // Write n words base+i; gap idle cycles before each; waits out in_ready=0 with a bound.
   task automatic fill(input int n, input int base, input int gap, input bit bd_chk);
      int w;
      for (int i = 0; i < n; i++) begin
         repeat (gap) begin
            bus.in_valid = 1'b0;
            @(posedge clk);
            #1;
         end
         bus.in_valid = 1'b1;
         bus.in_data  = DATA_W'(base + i);
         w = 0;
         @(negedge clk);
         while (!bus.in_ready && w < 400) begin
            chk("busy_no_write", {31'd0, bus.ram_we}, 32'd0);
            w++;
            @(negedge clk);
         end
         if (!bus.in_ready) chk("fill_timeout", 32'd1, 32'd0);
         if (i == 0 && bd_chk) chk("accept_with_block_done", {31'd0, bus.block_done}, 32'd1);
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      if (n == 64) begin
         for (int k = 0; k < 64; k++) exp_q.push_back(DATA_W'(base + (k % 8) * 8 + k / 8));
      end
   endtask

   task automatic wait_drain();
      int c;
      c = 0;
      while (exp_q.size() != 0 && c < 1000) begin
         @(negedge clk);
         c++;
      end
      chk("drain_timeout", exp_q.size(), 32'd0);
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      do_reset();

      // Basic block with latency check on the first output.
      fill(64, 0, 0, 1'b0);
      @(negedge clk);
      chk("prime_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("prime_in_ready", {31'd0, bus.in_ready}, 32'd0);
      @(negedge clk);
      chk("first_out_valid", {31'd0, bus.out_valid}, 32'd1);
      wait_drain();
`ifdef DCT_TC_STATUS_EN
      chk("frame_cnt_1", {16'd0, frame_cnt}, 32'd1);
      chk("drop_err_clean", {31'd0, drop_err}, 32'd0);
`endif

      // Stalling downstream.
      tog_mode = 1'b1;
      fill(64, 24'h100, 0, 1'b0);
      wait_drain();
      tog_mode = 1'b0;

      // Gapped upstream.
      fill(64, 24'h2000, 2, 1'b0);
      wait_drain();

      // Back-to-back blocks: second fill is offered during the first drain.
      do_reset();
      fill(64, 24'h30000, 0, 1'b0);
      fill(64, 24'h40000, 0, 1'b1);
      wait_drain();
`ifdef DCT_TC_STATUS_EN
      chk("frame_cnt_2", {16'd0, frame_cnt}, 32'd2);
      chk("drop_err_set", {31'd0, drop_err}, 32'd1);
`endif

      // Reset in the middle of a fill, then a fresh block.
      fill(40, 24'h500, 0, 1'b0);
      do_reset();
      fill(64, 24'h600, 0, 1'b0);
      wait_drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end
endmodule
